// File: rtl/pipe_pkg.sv
// Shared constants and types for the fetch/decode/execute pipeline register controller.
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;
  localparam int          CNT_W     = 16;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc_plus4: 32'h0, valid: 1'b0};

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter
  import pipe_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Sticks at all-ones rather than wrapping back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/pipe_reg_ctrl.sv
// PC, IF/ID and ID/EX pipeline registers steered by hazard-unit stall/flush requests.
module pipe_reg_ctrl
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CTRL_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Stall_IF,
  input  logic              Stall_ID,
  input  logic              Flush_EX,
  input  logic              PCSrc_ID,
  input  logic [31:0]       PCBranch_ID,
  input  logic [31:0]       Instr_IF,
  input  logic [CTRL_W-1:0] Ctrl_ID,
  output logic [31:0]       PC_IF,
  output logic [31:0]       Instr_ID,
  output logic [31:0]       PCPlus4_ID,
  output logic              Valid_ID,
  output logic              Valid_EX,
  output logic [CTRL_W-1:0] Ctrl_EX,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt
);

  logic [31:0]       pc_q, pc_d;
  ifid_t             ifid_q, ifid_d;
  logic [CTRL_W-1:0] ctrl_ex_q, ctrl_ex_d;
  logic              valid_ex_q, valid_ex_d;
  logic              redir;
  logic [31:0]       pc_plus4;

  // A stalled decode stage cannot act on its own branch decision.
  assign redir    = PCSrc_ID & ~Stall_ID;
  assign pc_plus4 = pc_q + PC_STEP;

  always_comb begin
    pc_d = pc_q;
    if (!Stall_IF) begin
      pc_d = redir ? PCBranch_ID : pc_plus4;
    end
  end

  always_comb begin
    ifid_d = ifid_q;
    if (!Stall_ID) begin
      if (redir) begin
        ifid_d = IFID_BUBBLE;
      end else begin
        ifid_d.instr    = Instr_IF;
        ifid_d.pc_plus4 = pc_plus4;
        ifid_d.valid    = 1'b1;
      end
    end
  end

  // ID/EX always advances; a flush inserts a bubble instead of holding.
  always_comb begin
    ctrl_ex_d  = Ctrl_ID;
    valid_ex_d = ifid_q.valid;
    if (Flush_EX) begin
      ctrl_ex_d  = '0;
      valid_ex_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      ifid_q     <= IFID_BUBBLE;
      ctrl_ex_q  <= '0;
      valid_ex_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ifid_q     <= ifid_d;
      ctrl_ex_q  <= ctrl_ex_d;
      valid_ex_q <= valid_ex_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (Stall_ID),
    .count (StallCnt)
  );

  // A flush and a redirect in the same cycle count as one event.
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (Flush_EX | redir),
    .count (FlushCnt)
  );

  assign PC_IF      = pc_q;
  assign Instr_ID   = ifid_q.instr;
  assign PCPlus4_ID = ifid_q.pc_plus4;
  assign Valid_ID   = ifid_q.valid;
  assign Ctrl_EX    = ctrl_ex_q;
  assign Valid_EX   = valid_ex_q;

endmodule

// File: doc/pipe_reg_ctrl.md
PIPE_REG_CTRL -- requirements
Module: pipe_reg_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter CTRL_W, default 32, width of the ID/EX control payload.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 Stall_IF  input  1  hold PC this cycle (from hazard unit).
REQ-006 Stall_ID  input  1  hold IF/ID register this cycle (from hazard unit).
REQ-007 Flush_EX  input  1  load bubble into ID/EX this cycle (from hazard unit).
REQ-008 PCSrc_ID  input  1  branch taken, resolved in ID.
REQ-009 PCBranch_ID  input  32  branch target.
REQ-010 Instr_IF  input  32  instruction fetched at PC_IF.
REQ-011 Ctrl_ID  input  CTRL_W  decoded control/operand payload leaving ID.
REQ-012 PC_IF  output  32  current fetch PC.
REQ-013 Instr_ID, PCPlus4_ID  output  32 each  IF/ID register contents.
REQ-014 Valid_ID, Valid_EX  output  1 each  stage holds a real instruction (0 = bubble).
REQ-015 Ctrl_EX  output  CTRL_W  ID/EX payload register.
REQ-016 StallCnt, FlushCnt  output  16 each  saturating performance counters.

Function
REQ-017 Effective branch redirect is Redir = PCSrc_ID & !Stall_ID; PCSrc_ID SHALL be ignored while Stall_ID=1.
REQ-018 PC update priority: Stall_IF=1 -> hold; else Redir=1 -> PCBranch_ID; else PC_IF+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-019 IF/ID update priority: Stall_ID=1 -> hold all fields; else Redir=1 -> Instr_ID=0 (NOP), PCPlus4_ID=0, Valid_ID=0; else Instr_ID=Instr_IF, PCPlus4_ID=PC_IF+4, Valid_ID=1.
REQ-020 ID/EX update: Flush_EX=1 -> Ctrl_EX=0, Valid_EX=0; else Ctrl_EX=Ctrl_ID, Valid_EX=Valid_ID; ID/EX never holds.
REQ-021 Flush_EX and Stall_ID both 1 (load-use): ID/EX gets bubble and IF/ID holds in the same cycle.
REQ-022 Stall_IF=0 with Stall_ID=1 is legal: PC advances, IF/ID holds; no error flag.
REQ-023 Latency: a registered input is visible on outputs one cycle after the capturing edge; no combinational path from inputs to outputs.
REQ-024 StallCnt increments by 1 each cycle Stall_ID=1; saturates at 16'hFFFF.
REQ-025 FlushCnt increments by 1 each cycle (Flush_EX | Redir)=1, once even if both are asserted; saturates at 16'hFFFF.

Reset
REQ-026 While rst=1 on an edge: PC_IF=RESET_PC, Instr_ID=0, PCPlus4_ID=0, Valid_ID=0, Ctrl_EX=0, Valid_EX=0, StallCnt=0, FlushCnt=0.
REQ-027 rst SHALL override Stall_*, Flush_EX and PCSrc_ID, including mid-stall.
REQ-028 First edge after rst deasserts fetches from RESET_PC as a normal PC+4 step.

Structure
REQ-029 Shared package pipe_pkg SHALL hold NOP_INSTR (32'h0), PC_STEP (4), CNT_W (16).
REQ-030 One sub-module sat_counter (width CNT_W, inc, rst) SHALL implement both counters.

Verification
REQ-031 Reset, then 3 free-running cycles with RESET_PC=0 -> PC_IF 0,4,8,12; Valid_ID=1 from cycle 2.
REQ-032 Load-use: Stall_IF=Stall_ID=Flush_EX=1 for 1 cycle at PC_IF=8 -> PC holds 8, Instr_ID unchanged, Valid_EX=0 next cycle, StallCnt=1, FlushCnt=1.
REQ-033 Taken branch: PCSrc_ID=1, PCBranch_ID=32'h100, no stall -> PC_IF=32'h100, Valid_ID=0 next cycle, FlushCnt+1.
REQ-034 PCSrc_ID=1 with Stall_ID=1 -> PC holds, IF/ID holds, FlushCnt unchanged.
REQ-035 PC wrap: PC_IF=32'hFFFF_FFFC, no stall -> PC_IF=0 next cycle.
REQ-036 Stall_ID held 70000 cycles -> StallCnt saturates at 16'hFFFF; rst pulse mid-stall -> all outputs per REQ-026.
